// File: rtl/pkt_tx_pkg.sv
// Shared constants, register map and state encoding for the framed packet transmitter.
package pkt_tx_pkg;

    localparam int unsigned ADDR_W      = 8;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned BYTE_W      = 8;

    localparam int unsigned MAX_PKT_DEF = 512;
    localparam int unsigned MIN_PKT_DEF = 64;
    localparam int unsigned IPG_MIN_DEF = 3;
    localparam int unsigned CNT_W_DEF   = 16;

    localparam logic [BYTE_W-1:0] PREAMBLE0 = 8'h55;
    localparam logic [BYTE_W-1:0] PREAMBLE1 = 8'hD5;

    localparam logic [ADDR_W-1:0] REG_CTRL = 8'h00;
    localparam logic [ADDR_W-1:0] REG_IPG  = 8'h04;
    localparam logic [ADDR_W-1:0] REG_SENT = 8'h08;
    localparam logic [ADDR_W-1:0] REG_DROP = 8'h0C;

    localparam logic [7:0] IPG_RST = 8'd12;

    typedef enum logic [2:0] {
        LOAD,
        FLUSH,
        CHK,
        READY,
        PRE0,
        PRE1,
        BODY,
        GAP
    } tx_state_t;

    // Effective gap: the programmed ipg, never below the receiver's recovery floor.
    function automatic logic [7:0] eff_gap(input logic [7:0] ipg, input int unsigned floor_v);
        return (ipg < 8'(floor_v)) ? 8'(floor_v) : ipg;
    endfunction

endpackage

// File: rtl/pkt_tx_if.sv
// Register bus, payload input stream and framed output link of the packet transmitter.
interface pkt_tx_if;
    import pkt_tx_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic              rw;
    logic              enable;
    logic [DATA_W-1:0] dout;

    logic [BYTE_W-1:0] in_data;
    logic              in_vld;
    logic              in_last;
    logic              in_rdy;

    logic [BYTE_W-1:0] txd;
    logic              tx_vld;

    modport master (
        output addr, din, rw, enable, in_data, in_vld, in_last,
        input  dout, in_rdy, txd, tx_vld
    );

    modport slave (
        input  addr, din, rw, enable, in_data, in_vld, in_last,
        output dout, in_rdy, txd, tx_vld
    );

endinterface

// File: rtl/pkt_tx_buf.sv
// Packet store: simple dual-port RAM with one write port and a registered read port.
module pkt_tx_buf
    import pkt_tx_pkg::*;
#(
    parameter int unsigned DEPTH = MAX_PKT_DEF - 2,
    parameter int unsigned AW    = 9,
    parameter int unsigned DW    = BYTE_W
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/pkt_tx.sv
// Store-and-forward framed packet transmitter: buffers one payload, then sends
// 0x55 0xD5 + payload with contiguous tx_vld and an enforced inter-packet gap.
module pkt_tx
    import pkt_tx_pkg::*;
#(
    parameter int unsigned MAX_PKT = MAX_PKT_DEF,
    parameter int unsigned MIN_PKT = MIN_PKT_DEF,
    parameter int unsigned IPG_MIN = IPG_MIN_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic     clk,
    input  logic     rst,
    pkt_tx_if.slave  bus
);

    localparam int unsigned DEPTH = MAX_PKT - 2;
    localparam int unsigned PTR_W = $clog2(MAX_PKT);

    tx_state_t state, state_d;

    logic [PTR_W-1:0]  wr_ptr, pkt_len, rd_cnt;
    logic [7:0]        gap_cnt, gap_len;
    logic              tx_en;
    logic [7:0]        ipg;
    logic [CNT_W-1:0]  sent_cnt, drop_cnt;

    logic              in_rdy_q, tx_vld_q;
    logic [BYTE_W-1:0] txd_q;

    logic              hs, wr_cmd;
    logic              sent_inc, drop_inc;
    logic              rd_en_c;
    logic [PTR_W-1:0]  rd_addr_c;
    logic              tx_vld_d;
    logic [BYTE_W-1:0] txd_d;
    logic [BYTE_W-1:0] rd_data;
    logic [DATA_W-1:0] dout_c;
    logic              unused_din;

    assign hs         = bus.in_vld & in_rdy_q;
    assign wr_cmd     = bus.enable & ~bus.rw;
    assign unused_din = ^bus.din[DATA_W-1:8];

    pkt_tx_buf #(
        .DEPTH (DEPTH),
        .AW    (PTR_W),
        .DW    (BYTE_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (hs && (state == LOAD)),
        .wr_addr (wr_ptr),
        .wr_data (bus.in_data),
        .rd_en   (rd_en_c),
        .rd_addr (rd_addr_c),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_d;
    end

    // Next state, next wire byte, and RAM read issued one cycle ahead of BODY.
    always_comb begin
        state_d   = state;
        tx_vld_d  = 1'b0;
        txd_d     = '0;
        sent_inc  = 1'b0;
        drop_inc  = 1'b0;
        rd_en_c   = 1'b0;
        rd_addr_c = '0;
        case (state)
            LOAD: begin
                if (hs) begin
                    if (bus.in_last)                         state_d = CHK;
                    else if (wr_ptr == PTR_W'(DEPTH - 1))    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (hs && bus.in_last) begin
                    drop_inc = 1'b1;
                    state_d  = LOAD;
                end
            end
            CHK: begin
                if (pkt_len < PTR_W'(MIN_PKT - 2)) begin
                    drop_inc = 1'b1;
                    state_d  = LOAD;
                end else begin
                    state_d  = READY;
                end
            end
            READY: begin
                if (tx_en) state_d = PRE0;
            end
            PRE0: begin
                tx_vld_d = 1'b1;
                txd_d    = PREAMBLE0;
                state_d  = PRE1;
            end
            PRE1: begin
                tx_vld_d  = 1'b1;
                txd_d     = PREAMBLE1;
                rd_en_c   = 1'b1;
                rd_addr_c = '0;
                state_d   = BODY;
            end
            BODY: begin
                tx_vld_d = 1'b1;
                txd_d    = rd_data;
                if (rd_cnt == pkt_len - PTR_W'(1)) begin
                    sent_inc = 1'b1;
                    state_d  = GAP;
                end else begin
                    rd_en_c   = 1'b1;
                    rd_addr_c = rd_cnt + PTR_W'(1);
                end
            end
            GAP: begin
                if (gap_cnt == gap_len) state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    // Pointers, gap timing and registered link outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            pkt_len  <= '0;
            rd_cnt   <= '0;
            gap_cnt  <= '0;
            gap_len  <= IPG_RST;
            in_rdy_q <= 1'b0;
            tx_vld_q <= 1'b0;
            txd_q    <= '0;
        end else begin
            in_rdy_q <= (state_d == LOAD) || (state_d == FLUSH);
            tx_vld_q <= tx_vld_d;
            txd_q    <= txd_d;

            if (state == LOAD) begin
                if (hs) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                    if (bus.in_last) pkt_len <= wr_ptr + PTR_W'(1);
                end
            end else begin
                wr_ptr <= '0;
            end

            if (state == BODY) rd_cnt <= rd_cnt + PTR_W'(1);
            else               rd_cnt <= '0;

            if (state == GAP) gap_cnt <= gap_cnt + 8'd1;
            else              gap_cnt <= '0;

            // Gap length is frozen as the packet ends so ipg writes land on the next gap.
            if (sent_inc) gap_len <= eff_gap(ipg, IPG_MIN);
        end
    end

    // Register file; a counter clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_en    <= 1'b0;
            ipg      <= IPG_RST;
            sent_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (wr_cmd && (bus.addr == REG_CTRL)) tx_en <= bus.din[0];
            if (wr_cmd && (bus.addr == REG_IPG))  ipg   <= bus.din[7:0];

            if (wr_cmd && (bus.addr == REG_SENT)) sent_cnt <= '0;
            else if (sent_inc)                    sent_cnt <= sent_cnt + CNT_W'(1);

            if (wr_cmd && (bus.addr == REG_DROP)) drop_cnt <= '0;
            else if (drop_inc)                    drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        dout_c = '0;
        case (bus.addr)
            REG_CTRL: dout_c = DATA_W'(tx_en);
            REG_IPG:  dout_c = DATA_W'(ipg);
            REG_SENT: dout_c = DATA_W'(sent_cnt);
            REG_DROP: dout_c = DATA_W'(drop_cnt);
            default:  dout_c = '0;
        endcase
    end

    assign bus.dout   = dout_c;
    assign bus.in_rdy = in_rdy_q;
    assign bus.tx_vld = tx_vld_q;
    assign bus.txd    = txd_q;

endmodule

// File: tb/tb_pkt_tx.sv
// Directed bench for pkt_tx: framing, drops, flush, gap timing, tx_en gating, reset.
module tb_pkt_tx;
    import pkt_tx_pkg::*;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    pkt_tx_if bus ();

    pkt_tx u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Wire monitor: bytes, packet lengths, start cycles, and gap before the buffer reopens.
    logic [7:0] wire_q [$];
    int         len_q [$];
    int         gap_q [$];
    int         start_q [$];
    int         run = 0;
    int         gcnt = 0;
    bit         gapping = 1'b0;
    bit         prev_vld = 1'b0;

    always @(negedge clk) begin
        if (bus.tx_vld === 1'b1) begin
            if (!prev_vld) start_q.push_back(cyc);
            wire_q.push_back(bus.txd);
            run = run + 1;
        end else begin
            if (run > 0) begin
                len_q.push_back(run);
                run     = 0;
                gapping = 1'b1;
                gcnt    = 0;
            end
            if (gapping) begin
                if (bus.in_rdy === 1'b1) begin
                    gap_q.push_back(gcnt);
                    gapping = 1'b0;
                end else begin
                    gcnt = gcnt + 1;
                end
            end
        end
        prev_vld = (bus.tx_vld === 1'b1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus.addr = a; bus.din = d; bus.rw = 1'b0; bus.enable = 1'b1;
        tick();
        bus.enable = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus.addr = a; bus.rw = 1'b1; bus.enable = 1'b1;
        #1;
        d = bus.dout;
        bus.enable = 1'b0; bus.rw = 1'b0;
        check(tag, d, exp);
    endtask

    task automatic send_pkt(input int len, input logic [7:0] base, output int stalls, output int last_cyc);
        int t;
        int done = 0;
        stalls   = 0;
        last_cyc = 0;
        for (int i = 0; i < len; i++) begin
            bus.in_data = base + 8'(i);
            bus.in_vld  = 1'b1;
            bus.in_last = (i == len - 1);
            t = 0;
            while (bus.in_rdy !== 1'b1 && t < 2000) begin
                tick();
                t++;
                stalls++;
            end
            if (t >= 2000) break;
            last_cyc = cyc;
            tick();
            done++;
        end
        bus.in_vld  = 1'b0;
        bus.in_last = 1'b0;
        check("send_done", 32'(done), 32'(len));
    endtask

    task automatic wait_len(input int n);
        int t = 0;
        while (len_q.size() < n && t < 3000) begin tick(); t++; end
        check("wait_pkt", 32'(len_q.size() >= n), 32'd1);
    endtask

    task automatic wait_wire(input int n);
        int t = 0;
        while (wire_q.size() < n && t < 3000) begin tick(); t++; end
        check("wait_wire", 32'(wire_q.size() >= n), 32'd1);
    endtask

    task automatic wait_rdy();
        int t = 0;
        while (bus.in_rdy !== 1'b1 && t < 3000) begin tick(); t++; end
        check("wait_rdy", 32'(bus.in_rdy), 32'd1);
    endtask

    function automatic int pkt_off(input int k);
        int s = 0;
        for (int i = 0; i < k; i++) s += len_q[i];
        return s;
    endfunction

    initial begin
        int st, lc, off, w0;
        rst = 1'b1;
        bus.addr = '0; bus.din = '0; bus.rw = 1'b0; bus.enable = 1'b0;
        bus.in_data = '0; bus.in_vld = 1'b0; bus.in_last = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        check("rst_tx_vld", 32'(bus.tx_vld), 32'd0);
        check("rst_txd", 32'(bus.txd), 32'd0);
        check("rst_in_rdy", 32'(bus.in_rdy), 32'd0);
        rst = 1'b0;
        chk_reg("rst_ctrl", REG_CTRL, 32'd0);
        chk_reg("rst_ipg", REG_IPG, 32'd12);
        chk_reg("rst_sent", REG_SENT, 32'd0);
        chk_reg("rst_drop", REG_DROP, 32'd0);
        chk_reg("unmapped", 8'h10, 32'd0);
        tick();

        // Minimum-length packet: 55 D5 00..3D, contiguous, 3-edge latency
        wr(REG_CTRL, 32'd1);
        chk_reg("ctrl_en", REG_CTRL, 32'd1);
        send_pkt(62, 8'h00, st, lc);
        wait_len(1);
        check("p0_len", 32'(len_q[0]), 32'd64);
        check("p0_pre0", 32'(wire_q[0]), 32'h55);
        check("p0_pre1", 32'(wire_q[1]), 32'hD5);
        for (int i = 0; i < 62; i++) check("p0_byte", 32'(wire_q[2 + i]), 32'(i));
        check("p0_latency", 32'(start_q[0] - (lc + 1)), 32'd3);
        chk_reg("p0_sent", REG_SENT, 32'd1);

        // Runt dropped, then a normal packet
        send_pkt(61, 8'h40, st, lc);
        repeat (20) tick();
        check("runt_no_tx", 32'(len_q.size()), 32'd1);
        chk_reg("runt_drop", REG_DROP, 32'd1);
        send_pkt(62, 8'h80, st, lc);
        wait_len(2);
        off = pkt_off(1);
        check("p1_len", 32'(len_q[1]), 32'd64);
        check("p1_first", 32'(wire_q[off + 2]), 32'h80);
        check("p1_last", 32'(wire_q[off + 63]), 32'hBD);
        chk_reg("p1_sent", REG_SENT, 32'd2);

        // Oversize flushed without stalling; max-size packet sent
        wr(REG_SENT, 32'd0);
        wr(REG_DROP, 32'd0);
        chk_reg("clr_sent", REG_SENT, 32'd0);
        wait_rdy();
        send_pkt(520, 8'h00, st, lc);
        check("flush_stalls", 32'(st), 32'd0);
        repeat (20) tick();
        check("flush_no_tx", 32'(len_q.size()), 32'd2);
        chk_reg("flush_drop", REG_DROP, 32'd1);
        send_pkt(510, 8'h00, st, lc);
        wait_len(3);
        off = pkt_off(2);
        check("max_len", 32'(len_q[2]), 32'd512);
        check("max_first", 32'(wire_q[off + 2]), 32'h00);
        check("max_last", 32'(wire_q[off + 511]), 32'hFD);
        chk_reg("max_sent", REG_SENT, 32'd1);

        // Gap floor with ipg=0; ipg written mid-gap applies to the following gap
        wr(REG_IPG, 32'd0);
        send_pkt(62, 8'h10, st, lc);
        send_pkt(62, 8'h20, st, lc);
        wait_len(5);
        wr(REG_IPG, 32'd20);
        check("gap_floor", 32'(gap_q[3]), 32'd3);
        send_pkt(62, 8'h30, st, lc);
        send_pkt(62, 8'h38, st, lc);
        wait_len(7);
        check("gap_latched", 32'(gap_q[4]), 32'd3);
        check("gap_20", 32'(gap_q[5]), 32'd20);
        off = pkt_off(4);
        check("b_first", 32'(wire_q[off + 2]), 32'h20);
        check("b_len", 32'(len_q[4]), 32'd64);

        // tx_en cleared mid-BODY: current packet completes, next holds in READY
        w0 = wire_q.size();
        send_pkt(62, 8'h70, st, lc);
        wait_wire(w0 + 20);
        wr(REG_CTRL, 32'd0);
        wait_len(8);
        check("en_off_len", 32'(len_q[7]), 32'd64);
        send_pkt(62, 8'h50, st, lc);
        repeat (120) tick();
        check("held_no_tx", 32'(len_q.size()), 32'd8);
        check("held_in_rdy", 32'(bus.in_rdy), 32'd0);
        chk_reg("held_sent", REG_SENT, 32'd6);
        wr(REG_CTRL, 32'd1);
        wait_len(9);
        off = pkt_off(8);
        check("rel_len", 32'(len_q[8]), 32'd64);
        check("rel_first", 32'(wire_q[off + 2]), 32'h50);

        // Reset mid-BODY
        wait_rdy();
        w0 = wire_q.size();
        send_pkt(62, 8'h60, st, lc);
        wait_wire(w0 + 20);
        rst = 1'b1;
        tick();
        check("rst_body_vld", 32'(bus.tx_vld), 32'd0);
        check("rst_body_txd", 32'(bus.txd), 32'd0);
        rst = 1'b0;
        chk_reg("rst_body_sent", REG_SENT, 32'd0);
        chk_reg("rst_body_drop", REG_DROP, 32'd0);
        chk_reg("rst_body_ctrl", REG_CTRL, 32'd0);
        chk_reg("rst_body_ipg", REG_IPG, 32'd12);
        wait_rdy();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
